filt_boxcar_mc: RTL
===================

# filt_boxcar_mc

Multi-channel, runtime-configurable moving-average (boxcar) filter with a valid/ready input handshake. Per-channel delay lines live in one distributed RAM. Channel samples arrive time-multiplexed, in any order, tagged by channel index. The block sits after the channelised ADC front end and feeds the detection chain with smoothed samples and a per-channel "window full" flag.

## Interface
- DATA_WIDTH, 16, signed sample width
- NUM_CHANNELS, 4, number of independent channels (≥1)
- MAX_POWER, 5, log2 of the maximum window; RAM depth per channel DEPTH = 2**MAX_POWER
- clk  in  1  system clock
- rst  in  1  reset; **one clock, reset asynchronous and active-high**
- len_pow  in  clog2(MAX_POWER+1)  window = 2**len_pow; values > MAX_POWER are clamped to MAX_POWER
- clear  in  1  synchronous request to flush all channels
- in_valid  in  1  input sample valid
- in_ready  out  1  block accepts a sample this cycle
- in_chan  in  clog2(NUM_CHANNELS) (min 1)  channel of data_in
- data_in  in  DATA_WIDTH  signed sample
- out_valid  out  1  result valid (single-cycle pulse per accepted input)
- out_chan  out  clog2(NUM_CHANNELS)  channel of avg_out
- avg_out  out  DATA_WIDTH  signed average
- out_full  out  1  channel has received ≥ 2**len_pow samples since the last flush

## Operation
- States: CLEAR, RUN. Reset enters CLEAR.
- CLEAR:
  - in_ready=0.
  - A counter walks RAM addresses 0..NUM_CHANNELS*DEPTH-1 and writes 0.
  - Per-channel accumulators, write pointers and fill counters are zeroed.
  - After the last address, move to RUN.
- RUN:
  - in_ready=1.
  - On in_valid&in_ready, with c=in_chan and p=len_pow (clamped):
    - oldest = RAM[c][(ptr[c] − 2**p) mod DEPTH], read combinationally.
    - acc[c] ← acc[c] + data_in − oldest.
    - RAM[c][ptr[c]] ← data_in.
    - ptr[c] ← ptr[c]+1, wrapping mod DEPTH.
    - fill[c] saturates at 2**MAX_POWER.
- When p=MAX_POWER, the read and write addresses coincide. The RAM must return the old data (read-before-write).
- Accumulator width is DATA_WIDTH+MAX_POWER, signed. It cannot overflow, so no saturation logic is needed.
- avg_out = acc/2**p, truncated toward zero:
  - non-negative: acc >>> p
  - negative: −((−acc) >> p)
  - The result always fits DATA_WIDTH.
- out_full = (fill[c] ≥ 2**p), evaluated with the post-update fill value.
- Flush triggers (RUN→CLEAR, taking effect the next cycle):
  - clear=1, or
  - len_pow differs from the value registered at the last flush.
- A sample presented in the same cycle as a flush trigger is still accepted and produces output. The flush then discards it.
- clear asserted during CLEAR restarts the walk from address 0.
- out_chan passes in_chan through.

## Timing
- Reset values: out_valid=0, avg_out=0, out_chan=0, out_full=0, in_ready=0, state=CLEAR.
- Reset may assert at any point mid-operation; all registers clear asynchronously. RAM contents are then rewritten by CLEAR.
- Latency: 1 cycle. An input accepted at edge k produces its out_valid/avg_out/out_chan/out_full registered at edge k+1.
- Throughput: 1 sample/cycle, including back-to-back samples on the same channel. No hazard, since the accumulator and pointer are registered state read in the same cycle.
- CLEAR lasts exactly NUM_CHANNELS*DEPTH cycles. in_ready rises on the cycle after the last RAM write.
- out_valid stays 0 throughout CLEAR.
- With in_valid=0, out_valid=0 next cycle and the data outputs hold.

## Structure
- Shared package filt_pkg:
  - state encoding (CLEAR, RUN)
  - clog2 helper function
  - accumulator width function
- Sub-module ram_dist_sdp:
  - simple dual-port distributed RAM
  - one synchronous write port, one asynchronous read port
  - parameterised width/depth
  - read-before-write on address collision
  - instantiated once with depth NUM_CHANNELS*DEPTH, address {chan, ptr}
- Controller, per-channel accumulators, pointers and fill counters stay in the top module.

## Test plan
All scenarios use DATA_WIDTH=16, NUM_CHANNELS=2, MAX_POWER=4, and wait out CLEAR first.
- Reset/CLEAR: release rst → in_ready=0 for exactly 32 cycles, then 1. All outputs remain 0 throughout.
- Step: len_pow=2, feed ch0 with 100 every cycle → avg_out = 25, 50, 75, 100, 100. out_full goes to 1 on the 4th output.
- Negative truncation: len_pow=1, ch0 samples −3, 0 → second avg_out = −1 (not −2).
- Interleaved channels: len_pow=2, ch0=+1000 and ch1=−1000 alternating for 8 samples. Final outputs: ch0 = 1000, ch1 = −1000. out_chan alternates correctly, with no cross-talk.
- Max window and wrap: len_pow=4, feed 0..39 on ch1 → avg_out after sample n≥15 equals trunc((16n−120)/16), e.g. n=39 → 31. This exercises read-before-write collision and pointer wrap.
- Flush:
  - Change len_pow 2→3 mid-stream → in_ready drops the next cycle for 32 cycles. The first post-flush sample 80 yields avg_out=10 and out_full=0.
  - Repeat using clear=1 instead of a len_pow change; same result.
  - Assert rst mid-stream → all outputs return to reset values immediately.

Source files
------------

// File: rtl/filt_pkg.sv
// Shared definitions for the boxcar filter: controller states and width helpers.
package filt_pkg;

  typedef enum logic [0:0] {
    StClear,
    StRun
  } state_e;

  // Bit count needed to index n items, never less than one bit.
  function automatic int unsigned clog2_min1(input int unsigned n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

  // A window of 2**max_pow samples of dw-bit data sums without overflow in this width.
  function automatic int unsigned acc_width(input int unsigned dw, input int unsigned max_pow);
    return dw + max_pow;
  endfunction

endpackage

// File: rtl/ram_dist_sdp.sv
// Simple dual-port distributed RAM: synchronous write, asynchronous read.
// A read of the address being written returns the old contents.
module ram_dist_sdp #(
  parameter int unsigned Width     = 16,
  parameter int unsigned Depth     = 64,
  parameter int unsigned AddrWidth = 6
) (
  input  logic                 clk,
  input  logic                 we,
  input  logic [AddrWidth-1:0] waddr,
  input  logic [Width-1:0]     wdata,
  input  logic [AddrWidth-1:0] raddr,
  output logic [Width-1:0]     rdata
);

  logic [Width-1:0] mem [Depth];

  // Write port; the combinational read below sees the pre-edge value.
  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/filt_boxcar_mc.sv
// Multi-channel moving-average filter with a shared delay-line RAM.
module filt_boxcar_mc
  import filt_pkg::*;
#(
  parameter int unsigned DATA_WIDTH   = 16,
  parameter int unsigned NUM_CHANNELS = 4,
  parameter int unsigned MAX_POWER    = 5,
  localparam int unsigned LenW        = clog2_min1(MAX_POWER + 1),
  localparam int unsigned ChanW       = clog2_min1(NUM_CHANNELS)
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [LenW-1:0]              len_pow,
  input  logic                         clear,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic [ChanW-1:0]             in_chan,
  input  logic signed [DATA_WIDTH-1:0] data_in,
  output logic                         out_valid,
  output logic [ChanW-1:0]             out_chan,
  output logic signed [DATA_WIDTH-1:0] avg_out,
  output logic                         out_full
);

  localparam int unsigned Depth    = 2 ** MAX_POWER;
  localparam int unsigned RamDepth = NUM_CHANNELS * Depth;
  localparam int unsigned AddrW    = ChanW + MAX_POWER;
  localparam int unsigned AccW     = acc_width(DATA_WIDTH, MAX_POWER);

  localparam logic [AddrW-1:0]   LastAddr = AddrW'(RamDepth - 1);
  localparam logic [LenW-1:0]    MaxPow   = LenW'(MAX_POWER);
  localparam logic [MAX_POWER:0] One      = 1;
  localparam logic [MAX_POWER:0] FillMax  = One << MAX_POWER;

  state_e                 state_q, state_d;
  logic [AddrW-1:0]       clr_addr_q, clr_addr_d;
  logic [LenW-1:0]        len_q;
  logic signed [AccW-1:0] acc_q  [NUM_CHANNELS];
  logic [MAX_POWER-1:0]   ptr_q  [NUM_CHANNELS];
  logic [MAX_POWER:0]     fill_q [NUM_CHANNELS];

  logic                         out_valid_q, out_full_q;
  logic [ChanW-1:0]             out_chan_q;
  logic signed [DATA_WIDTH-1:0] avg_q;

  logic                         fire, flush, full_new;
  logic [LenW-1:0]              pow;
  logic [MAX_POWER:0]           win, fill_cur, fill_new;
  logic [MAX_POWER-1:0]         ptr_cur, rd_ptr;
  logic signed [AccW-1:0]       acc_cur, acc_new, din_ext, old_ext;
  logic [AccW-1:0]              mag, mag_sh;
  logic signed [DATA_WIDTH-1:0] avg_new;

  logic                  ram_we;
  logic [AddrW-1:0]      ram_waddr, ram_raddr;
  logic [DATA_WIDTH-1:0] ram_wdata, ram_rdata;

  assign in_ready = (state_q == StRun);
  assign fire     = in_valid & in_ready;
  assign flush    = in_ready & (clear | (len_pow != len_q));
  assign pow      = (len_pow > MaxPow) ? MaxPow : len_pow;
  assign win      = One << pow;

  // Per-channel datapath: drop the sample leaving the window, add the new one.
  always_comb begin
    ptr_cur  = ptr_q[in_chan];
    acc_cur  = acc_q[in_chan];
    fill_cur = fill_q[in_chan];
    // At full window the offset wraps to zero, so read and write hit the same slot.
    rd_ptr   = ptr_cur - MAX_POWER'(win);
    din_ext  = {{MAX_POWER{data_in[DATA_WIDTH-1]}}, data_in};
    old_ext  = {{MAX_POWER{ram_rdata[DATA_WIDTH-1]}}, ram_rdata};
    acc_new  = acc_cur + din_ext - old_ext;
    // Divide the magnitude so negative averages truncate toward zero.
    mag      = acc_new[AccW-1] ? -acc_new : acc_new;
    mag_sh   = mag >> pow;
    avg_new  = acc_new[AccW-1] ? DATA_WIDTH'(-mag_sh) : DATA_WIDTH'(mag_sh);
    fill_new = (fill_cur == FillMax) ? fill_cur : fill_cur + (MAX_POWER + 1)'(1);
    full_new = (fill_new >= win);
  end

  // RAM port steering: CLEAR walks zeros through memory, RUN writes the sample.
  always_comb begin
    ram_we    = fire;
    ram_waddr = {in_chan, ptr_cur};
    ram_wdata = data_in;
    ram_raddr = {in_chan, rd_ptr};
    if (state_q == StClear) begin
      ram_we    = 1'b1;
      ram_waddr = clr_addr_q;
      ram_wdata = '0;
    end
  end

  ram_dist_sdp #(
    .Width     (DATA_WIDTH),
    .Depth     (RamDepth),
    .AddrWidth (AddrW)
  ) u_ram (
    .clk   (clk),
    .we    (ram_we),
    .waddr (ram_waddr),
    .wdata (ram_wdata),
    .raddr (ram_raddr),
    .rdata (ram_rdata)
  );

  // Controller next state: clear walk, restart on clear, flush from RUN.
  always_comb begin
    state_d    = state_q;
    clr_addr_d = clr_addr_q;
    unique case (state_q)
      StClear: begin
        if (clear) begin
          clr_addr_d = '0;
        end else if (clr_addr_q == LastAddr) begin
          state_d    = StRun;
          clr_addr_d = '0;
        end else begin
          clr_addr_d = clr_addr_q + AddrW'(1);
        end
      end
      StRun: begin
        if (flush) begin
          state_d    = StClear;
          clr_addr_d = '0;
        end
      end
      default: state_d = StClear;
    endcase
  end

  // Controller registers; the window setting is captured throughout CLEAR.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= StClear;
      clr_addr_q <= '0;
      len_q      <= '0;
    end else begin
      state_q    <= state_d;
      clr_addr_q <= clr_addr_d;
      if (state_q == StClear) begin
        len_q <= len_pow;
      end
    end
  end

  // Per-channel accumulators, pointers and fill counters.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NUM_CHANNELS; i++) begin
        acc_q[i]  <= '0;
        ptr_q[i]  <= '0;
        fill_q[i] <= '0;
      end
    end else if (state_q == StClear) begin
      for (int i = 0; i < NUM_CHANNELS; i++) begin
        acc_q[i]  <= '0;
        ptr_q[i]  <= '0;
        fill_q[i] <= '0;
      end
    end else if (fire) begin
      acc_q[in_chan]  <= acc_new;
      ptr_q[in_chan]  <= ptr_cur + MAX_POWER'(1);
      fill_q[in_chan] <= fill_new;
    end
  end

  // Output registers; data outputs hold when no sample is accepted.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid_q <= 1'b0;
      out_chan_q  <= '0;
      avg_q       <= '0;
      out_full_q  <= 1'b0;
    end else begin
      out_valid_q <= fire;
      if (fire) begin
        out_chan_q <= in_chan;
        avg_q      <= avg_new;
        out_full_q <= full_new;
      end
    end
  end

  assign out_valid = out_valid_q;
  assign out_chan  = out_chan_q;
  assign avg_out   = avg_q;
  assign out_full  = out_full_q;

endmodule
